// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Package : muldiv_pkg
// Brief   : Opcode/state encodings and opcode classification helpers.
// Rev     : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULH  = 3'd1,
        OP_MULHU = 3'd3,
        OP_DIV   = 3'd4,
        OP_DIVU  = 3'd5,
        OP_MOD   = 3'd6,
        OP_MODU  = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : muldiv_unit_if
// Brief     : Request/response handshake bundle between EX and muldiv_unit.
// Rev       : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_rs0;
    logic [WIDTH-1:0] req_rs1;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             busy;

    modport master (
        output flush, req_valid, req_op, req_rs0, req_rs1, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  flush, req_valid, req_op, req_rs0, req_rs1, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module : div_step
// Brief  : Combinational restoring-division step retiring DIV_BITS quotient bits.
// Rev    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH    = 32,
    parameter int DIV_BITS = 1
) (
    input  logic [WIDTH-1:0]    i_rem,
    input  logic [WIDTH-1:0]    i_dvd,
    input  logic [WIDTH-1:0]    i_dvs,
    output logic [WIDTH-1:0]    o_rem,
    output logic [WIDTH-1:0]    o_dvd,
    output logic [DIV_BITS-1:0] o_qbits
);
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_dvd;
    logic [WIDTH-1:0] w_sh;
    logic             w_ge;

    always_comb begin
        w_rem   = i_rem;
        w_dvd   = i_dvd;
        w_sh    = '0;
        w_ge    = 1'b0;
        o_qbits = '0;
        for (int k = DIV_BITS - 1; k >= 0; k--) begin
            // A set MSB before the shift means the shifted value exceeds any divisor.
            w_sh       = {w_rem[WIDTH-2:0], w_dvd[WIDTH-1]};
            w_ge       = w_rem[WIDTH-1] | (w_sh >= i_dvs);
            w_rem      = w_ge ? (w_sh - i_dvs) : w_sh;
            w_dvd      = {w_dvd[WIDTH-2:0], 1'b0};
            o_qbits[k] = w_ge;
        end
        o_rem = w_rem;
        o_dvd = w_dvd;
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Brief  : Multi-cycle multiply/divide unit with valid/ready handshakes and flush.
// Rev    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DIV_BITS = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int PW      = 2 * WIDTH;
    localparam int DIV_CYC = WIDTH / DIV_BITS;
    localparam int CNT_MAX = (DIV_CYC > MUL_LAT) ? DIV_CYC : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_MUL  = ST_MUL;
    localparam logic [2:0] S_DIV  = ST_DIV;
    localparam logic [2:0] S_FIX  = ST_FIX;
    localparam logic [2:0] S_DONE = ST_DONE;

    logic [2:0]       r_state;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_data;
    logic [PW-1:0]    r_pipe [MUL_LAT];

    logic                w_req_ready;
    logic                w_accept;
    logic                w_sgn;
    logic                w_neg0;
    logic                w_neg1;
    logic [WIDTH-1:0]    w_abs0;
    logic [WIDTH-1:0]    w_abs1;
    logic [PW-1:0]       w_ext0;
    logic [PW-1:0]       w_ext1;
    logic [PW-1:0]       w_prod;
    logic [PW-1:0]       w_pout;
    logic [WIDTH-1:0]    w_mul_res;
    logic [WIDTH-1:0]    w_fix;
    logic [WIDTH-1:0]    w_step_rem;
    logic [WIDTH-1:0]    w_step_dvd;
    logic [DIV_BITS-1:0] w_step_q;

    assign w_req_ready = ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.resp_ready)) & ~bus.flush;
    assign w_accept    = bus.req_valid & w_req_ready;

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (r_state == S_DONE);
    assign bus.resp_data  = r_data;
    assign bus.busy       = (r_state != S_IDLE);

    // Operand conditioning: one 2*WIDTH multiplier serves signed and unsigned forms.
    assign w_sgn  = is_signed_op(bus.req_op);
    assign w_neg0 = w_sgn & bus.req_rs0[WIDTH-1];
    assign w_neg1 = w_sgn & bus.req_rs1[WIDTH-1];
    assign w_abs0 = w_neg0 ? -bus.req_rs0 : bus.req_rs0;
    assign w_abs1 = w_neg1 ? -bus.req_rs1 : bus.req_rs1;
    assign w_ext0 = {{WIDTH{w_sgn & bus.req_rs0[WIDTH-1]}}, bus.req_rs0};
    assign w_ext1 = {{WIDTH{w_sgn & bus.req_rs1[WIDTH-1]}}, bus.req_rs1};
    assign w_prod = w_ext0 * w_ext1;

    assign w_pout    = r_pipe[MUL_LAT-1];
    assign w_mul_res = (r_op == OP_MUL) ? w_pout[WIDTH-1:0] : w_pout[PW-1:WIDTH];

    assign w_fix = is_rem_op(r_op) ? (r_neg_r ? -r_rem : r_rem)
                                   : (r_neg_q ? -r_quo : r_quo);

    div_step #(
        .WIDTH    (WIDTH),
        .DIV_BITS (DIV_BITS)
    ) u_div_step (
        .i_rem   (r_rem),
        .i_dvd   (r_dvd),
        .i_dvs   (r_dvs),
        .o_rem   (w_step_rem),
        .o_dvd   (w_step_dvd),
        .o_qbits (w_step_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MUL_LAT; k++) r_pipe[k] <= '0;
        end else begin
            if (w_accept && is_mul_op(bus.req_op)) r_pipe[0] <= w_prod;
            for (int k = 1; k < MUL_LAT; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_data  <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else if (w_accept) begin
            r_op <= bus.req_op;
            if (is_mul_op(bus.req_op)) begin
                r_state <= S_MUL;
                r_cnt   <= CW'(MUL_LAT);
            end else if (is_div_op(bus.req_op)) begin
                if (bus.req_rs1 == '0) begin
                    r_state <= S_DONE;
                    r_data  <= is_rem_op(bus.req_op) ? bus.req_rs0 : '1;
                end else begin
                    r_state <= S_DIV;
                    r_cnt   <= CW'(DIV_CYC);
                    r_rem   <= '0;
                    r_dvd   <= w_abs0;
                    r_dvs   <= w_abs1;
                    r_quo   <= '0;
                    r_neg_q <= w_neg0 ^ w_neg1;
                    r_neg_r <= w_neg0;
                end
            end else begin
                r_state <= S_DONE;
                r_data  <= '0;
            end
        end else begin
            case (r_state)
                S_MUL: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                        r_data  <= w_mul_res;
                    end
                end
                S_DIV: begin
                    r_rem <= w_step_rem;
                    r_dvd <= w_step_dvd;
                    r_quo <= {r_quo[WIDTH-DIV_BITS-1:0], w_step_q};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_data  <= w_fix;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.resp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Directed bench for muldiv_unit (DIV_BITS=1 and DIV_BITS=2 instances).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    localparam int W  = 32;
    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b1;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] rs0 = '0;
    logic [31:0] rs1 = '0;

    logic        d_ready, d_valid, d_busy;
    logic [31:0] d_data;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit_if #(.WIDTH(W)) ifa ();
    muldiv_unit_if #(.WIDTH(W)) ifb ();

    assign ifa.flush      = flush & ~sel;
    assign ifa.req_valid  = req_valid & ~sel;
    assign ifa.req_op     = req_op;
    assign ifa.req_rs0    = rs0;
    assign ifa.req_rs1    = rs1;
    assign ifa.resp_ready = resp_ready;
    assign ifb.flush      = flush & sel;
    assign ifb.req_valid  = req_valid & sel;
    assign ifb.req_op     = req_op;
    assign ifb.req_rs0    = rs0;
    assign ifb.req_rs1    = rs1;
    assign ifb.resp_ready = resp_ready;

    assign d_ready = sel ? ifb.req_ready  : ifa.req_ready;
    assign d_valid = sel ? ifb.resp_valid : ifa.resp_valid;
    assign d_busy  = sel ? ifb.busy       : ifa.busy;
    assign d_data  = sel ? ifb.resp_data  : ifa.resp_data;

    muldiv_unit #(.WIDTH(W), .DIV_BITS(1), .MUL_LAT(ML)) u_dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    muldiv_unit #(.WIDTH(W), .DIV_BITS(2), .MUL_LAT(ML)) u_dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        logic               ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        sp  = sa * sb;
        up  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return up[31:0];
            3'd1: return sp[63:32];
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            3'd7: begin
                if (b == 0) return a;
                return a % b;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] b, input int db);
        if (op == 3'd2) return 1;
        if (op == 3'd0 || op == 3'd1 || op == 3'd3) return ML + 1;
        if (b == 0) return 1;
        return W / db + 2;
    endfunction

    // Cycle-level reference: one outstanding op, response due a fixed latency after accept.
    bit          chk_en = 1'b0;
    bit          m_pend = 1'b0;
    int          m_due = 0;
    logic [31:0] m_data = '0;
    bit          m_ev, m_er;

    always @(negedge clk) begin
        if (chk_en) begin
            m_ev = m_pend && (cyc >= m_due);
            m_er = (!m_pend || (m_ev && resp_ready)) && !flush;
            check32("model resp_valid", {31'd0, d_valid}, {31'd0, m_ev});
            check32("model busy",       {31'd0, d_busy},  {31'd0, m_pend});
            check32("model req_ready",  {31'd0, d_ready}, {31'd0, m_er});
            if (m_ev) check32("model resp_data", d_data, m_data);
            if (flush) begin
                m_pend = 1'b0;
            end else if (req_valid && m_er) begin
                m_pend = 1'b1;
                m_due  = cyc + model_lat(req_op, rs1, sel ? 2 : 1);
                m_data = model_res(req_op, rs0, rs1);
            end else if (m_ev && resp_ready) begin
                m_pend = 1'b0;
            end
        end
    end

    task automatic wait_resp(output int tv, output logic [31:0] d);
        tv = -1;
        d  = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (d_valid) begin
                tv = cyc;
                d  = d_data;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_resp: got no resp_valid expected one within 200 cycles");
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          t, tv;
        logic [31:0] d;
        bit          ok;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_op     = op;
        rs0        = a;
        rs1        = b;
        resp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d_ready) begin
                ok = 1'b1;
                break;
            end
        end
        t = cyc;
        check32({name, " accepted"}, {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rs0 = $urandom;
        rs1 = $urandom;
        wait_resp(tv, d);
        check32({name, " data"}, d, exp);
        check32({name, " latency"}, tv - t, lat);
    endtask

    task automatic div_suite(input int lat);
        run_op("DIVU 100/7",  3'd5, 32'd100,        32'd7,          32'd14,         lat);
        run_op("MODU 100/7",  3'd7, 32'd100,        32'd7,          32'd2,          lat);
        run_op("DIV -7/2",    3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  lat);
        run_op("MOD -7/2",    3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  lat);
        run_op("DIV 7/-2",    3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  lat);
        run_op("MOD 7/-2",    3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          lat);
        run_op("DIV -8/-2",   3'd4, 32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          lat);
        run_op("DIV ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  lat);
        run_op("MOD ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          lat);
        run_op("DIVU max/3",  3'd5, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  lat);
        run_op("DIVU 5/0",    3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        run_op("MODU 5/0",    3'd7, 32'd5,          32'd0,          32'd5,          1);
        run_op("MOD -9/0",    3'd6, 32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7,  1);
    endtask

    int          t0, tv0;
    logic [31:0] d0;

    initial begin
        repeat (3) @(negedge clk);
        check32("reset A resp_valid", {31'd0, ifa.resp_valid}, 32'd0);
        check32("reset A resp_data",  ifa.resp_data,           32'd0);
        check32("reset A busy",       {31'd0, ifa.busy},       32'd0);
        check32("reset B resp_valid", {31'd0, ifb.resp_valid}, 32'd0);
        check32("reset B busy",       {31'd0, ifb.busy},       32'd0);
        @(posedge clk); #1;
        rst    = 1'b1;
        chk_en = 1'b1;

        div_suite(W + 2);
        run_op("MULH -1*-1",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         ML + 1);
        run_op("MULHU -1*-1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML + 1);
        run_op("MUL -1*-1",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         ML + 1);
        run_op("MULH -3*5",   3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, ML + 1);
        run_op("MUL -3*5",    3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, ML + 1);
        run_op("MULHU 2^16sq",3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1,         ML + 1);
        run_op("illegal op",  3'd2, 32'd12,        32'd34,        32'd0,         1);

        // Flush a signed divide mid-flight; a request offered during the flush is ignored.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd4; rs0 = 32'hFFFF_FF9C; rs1 = 32'd7; resp_ready = 1'b1;
        @(negedge clk);
        check32("flush: first accept ready", {31'd0, d_ready}, 32'd1);
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd5; rs0 = 32'd9; rs1 = 32'd3;
        @(negedge clk);
        check32("flush cycle busy",      {31'd0, d_busy},  32'd1);
        check32("flush cycle req_ready", {31'd0, d_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check32("after flush busy",      {31'd0, d_busy},  32'd0);
        check32("after flush req_ready", {31'd0, d_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(tv0, d0);
        check32("post-flush DIVU 9/3 data",    d0,       32'd3);
        check32("post-flush DIVU 9/3 latency", tv0 - t0, 32'd45);

        // Stall the consumer in DONE, then hand off and issue in the same cycle.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd5; rs0 = 32'd100; rs1 = 32'd7; resp_ready = 1'b0;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(tv0, d0);
        check32("stall DIVU latency", tv0 - t0, W + 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("stall resp_valid", {31'd0, d_valid}, 32'd1);
            check32("stall resp_data",  d_data,           32'd14);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1; req_valid = 1'b1; req_op = 3'd3; rs0 = 32'hFFFF_FFFF; rs1 = 32'hFFFF_FFFF;
        @(negedge clk);
        check32("handoff req_ready", {31'd0, d_ready}, 32'd1);
        check32("handoff old data",  d_data,           32'd14);
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(tv0, d0);
        check32("handoff MULHU data",    d0,       32'hFFFF_FFFE);
        check32("handoff MULHU latency", tv0 - t0, ML + 1);

        @(posedge clk); #1;
        sel = 1'b1;
        div_suite(W / 2 + 2);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
